// File: rtl/hw_stack.sv
// LIFO data stack answering the decoder's stack_en/stack_rw/stack_rst lines.
// Latency: the popped word appears on dout one cycle after the pop edge. There is no backpressure: overflow and underflow set sticky flags.
module hw_stack #(
  parameter int WIDTH = 16,
  parameter int PTR_W = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             stack_en,
  input  logic             stack_rw,
  input  logic             stack_rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full,
  output logic [PTR_W:0]   count,
  output logic             ovf,
  output logic             udf,
  output logic             pop_ack
);

  localparam int             DEPTH_N = 1 << PTR_W;
  localparam logic [PTR_W:0] DEPTH   = {1'b1, {PTR_W{1'b0}}};
  localparam logic [PTR_W:0] ONE_C   = {{PTR_W{1'b0}}, 1'b1};

  logic [WIDTH-1:0] mem_q [0:DEPTH_N-1];

  logic [PTR_W:0]   count_q, count_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             ovf_q, ovf_d;
  logic             udf_q, udf_d;
  logic             pop_ack_q, pop_ack_d;
  logic             pop_seen_q, pop_seen_d;

  logic             push_req, pop_req;
  logic             mem_we;
  logic [PTR_W-1:0] wr_idx, rd_idx;

  assign empty = (count_q == '0);
  assign full  = (count_q == DEPTH);

  // sp is the low bits of count; the top entry sits one below it
  assign wr_idx = count_q[PTR_W-1:0];
  assign rd_idx = count_q[PTR_W-1:0] - ONE_C[PTR_W-1:0];

  // A held POP level counts once; any non-POP cycle re-arms the detector
  assign push_req = stack_en & ~stack_rw;
  assign pop_req  = stack_en & stack_rw & ~pop_seen_q;

  always_comb begin
    count_d    = count_q;
    dout_d     = dout_q;
    ovf_d      = ovf_q;
    udf_d      = udf_q;
    pop_ack_d  = 1'b0;
    pop_seen_d = stack_en & stack_rw;
    mem_we     = 1'b0;
    if (stack_rst) begin
      count_d    = '0;
      dout_d     = '0;
      ovf_d      = 1'b0;
      udf_d      = 1'b0;
      pop_seen_d = 1'b0;
    end else if (push_req) begin
      if (full) begin
        ovf_d = 1'b1;
      end else begin
        mem_we  = 1'b1;
        count_d = count_q + ONE_C;
      end
    end else if (pop_req) begin
      pop_ack_d = 1'b1;
      if (empty) begin
        dout_d = '0;
        udf_d  = 1'b1;
      end else begin
        dout_d  = mem_q[rd_idx];
        count_d = count_q - ONE_C;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      count_q    <= '0;
      dout_q     <= '0;
      ovf_q      <= 1'b0;
      udf_q      <= 1'b0;
      pop_ack_q  <= 1'b0;
      pop_seen_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      dout_q     <= dout_d;
      ovf_q      <= ovf_d;
      udf_q      <= udf_d;
      pop_ack_q  <= pop_ack_d;
      pop_seen_q <= pop_seen_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (mem_we && !RST) begin
      mem_q[wr_idx] <= din;
    end
  end

  assign dout    = dout_q;
  assign count   = count_q;
  assign ovf     = ovf_q;
  assign udf     = udf_q;
  assign pop_ack = pop_ack_q;

endmodule
